// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational ULA between two requesters.
// Optional per-requester completion counters under `ULA_ARB_STATS_EN`.
module ula_arbiter #(
    parameter int W  = 5,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [SW-1:0] req0_op,
    input  logic [W-1:0]  req0_a,
    input  logic [W-1:0]  req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [SW-1:0] req1_op,
    input  logic [W-1:0]  req1_a,
    input  logic [W-1:0]  req1_b,
    output logic          rsp0_valid,
    output logic          rsp1_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_o,
    output logic          rsp_cout,
    output logic          rsp_zero,
    output logic [SW-1:0] alu_s,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic          alu_r,
    input  logic [W-1:0]  alu_o,
    input  logic          alu_cout,
    input  logic          alu_zero
`ifdef ULA_ARB_STATS_EN
    ,
    output logic [7:0]    ops0_cnt,
    output logic [7:0]    ops1_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state;
    logic          prio;
    logic          owner;
    logic [SW-1:0] op_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          grant0;
    logic          grant1;

    // prio only matters when both requesters are valid in the same cycle
    assign grant0     = req0_valid & (~req1_valid | ~prio);
    assign grant1     = req1_valid & (~req0_valid | prio);
    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;

    assign alu_s = op_q;
    assign alu_a = a_q;
    assign alu_b = b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prio       <= 1'b0;
            owner      <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            alu_r      <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_o      <= '0;
            rsp_cout   <= 1'b0;
            rsp_zero   <= 1'b0;
`ifdef ULA_ARB_STATS_EN
            ops0_cnt   <= '0;
            ops1_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready | req1_ready) begin
                        owner <= req1_ready;
                        op_q  <= req1_ready ? req1_op : req0_op;
                        a_q   <= req1_ready ? req1_a  : req0_a;
                        b_q   <= req1_ready ? req1_b  : req0_b;
                        alu_r <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_o      <= alu_o;
                    rsp_cout   <= alu_cout;
                    rsp_zero   <= alu_zero;
                    alu_r      <= 1'b0;
                    rsp0_valid <= ~owner;
                    rsp1_valid <= owner;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        prio       <= ~owner;
                        state      <= IDLE;
`ifdef ULA_ARB_STATS_EN
                        if (!owner && ops0_cnt != 8'hFF) ops0_cnt <= ops0_cnt + 8'd1;
                        if (owner && ops1_cnt != 8'hFF)  ops1_cnt <= ops1_cnt + 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: fake ULA, transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_ula_arbiter;

    localparam int W  = 5;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 0, req1_valid = 0, rsp_ready = 0;
    logic [SW-1:0] req0_op = '0, req1_op = '0;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [W-1:0]  rsp_o;
    logic          rsp_cout, rsp_zero;
    logic [SW-1:0] alu_s;
    logic [W-1:0]  alu_a, alu_b, alu_o;
    logic          alu_r, alu_cout, alu_zero;
`ifdef ULA_ARB_STATS_EN
    logic [7:0]    ops0_cnt, ops1_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ula_arbiter #(.W(W), .SW(SW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_ready(rsp_ready),
        .rsp_o(rsp_o), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero),
        .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r),
        .alu_o(alu_o), .alu_cout(alu_cout), .alu_zero(alu_zero)
`ifdef ULA_ARB_STATS_EN
        , .ops0_cnt(ops0_cnt), .ops1_cnt(ops1_cnt)
`endif
    );

    // Stand-in ULA: {cout, o}
    function automatic logic [W:0] ula_f(input logic [SW-1:0] s, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        case (s)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {(a < b), a - b};
            4'd2:    return {1'b0, a & b};
            4'd3:    return {1'b0, a | b};
            4'd4:    return {1'b0, a ^ b};
            4'd15:   return {1'b0, b};
            default: return {1'b0, a};
        endcase
    endfunction

    always_comb begin
        {alu_cout, alu_o} = ula_f(alu_s, alu_a, alu_b);
        alu_zero = (alu_o == '0);
    end

    task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_age 0 = free, 1 = op executing, 2 = result waiting
    bit            m_ok = 0;
    int            m_age;
    bit            m_prio, m_owner;
    logic [SW-1:0] m_op;
    logic [W-1:0]  m_a, m_b, m_o;
    bit            m_cout, m_zero;
    int            m_cnt[2];

    always @(negedge clk) begin
        bit e0, e1;
        logic [W:0] r;
        e0 = (m_age == 0) && req0_valid && (!req1_valid || !m_prio);
        e1 = (m_age == 0) && req1_valid && (!req0_valid || m_prio);
        if (m_ok) begin
            ck("req0_ready", req0_ready, e0);
            ck("req1_ready", req1_ready, e1);
            ck("rsp0_valid", rsp0_valid, (m_age == 2) && !m_owner);
            ck("rsp1_valid", rsp1_valid, (m_age == 2) && m_owner);
            ck("alu_r", alu_r, m_age == 1);
            ck("alu_s", alu_s, m_op);
            ck("alu_a", alu_a, m_a);
            ck("alu_b", alu_b, m_b);
            ck("rsp_o", rsp_o, m_o);
            ck("rsp_cout", rsp_cout, m_cout);
            ck("rsp_zero", rsp_zero, m_zero);
`ifdef ULA_ARB_STATS_EN
            ck("ops0_cnt", ops0_cnt, m_cnt[0]);
            ck("ops1_cnt", ops1_cnt, m_cnt[1]);
`endif
        end
        if (rst) begin
            m_ok = 1; m_age = 0; m_prio = 0; m_owner = 0;
            m_op = '0; m_a = '0; m_b = '0; m_o = '0; m_cout = 0; m_zero = 0;
            m_cnt[0] = 0; m_cnt[1] = 0;
        end else if (m_ok) begin
            if (m_age == 0 && (e0 || e1)) begin
                m_owner = e1;
                m_op = e1 ? req1_op : req0_op;
                m_a  = e1 ? req1_a  : req0_a;
                m_b  = e1 ? req1_b  : req0_b;
                m_age = 1;
            end else if (m_age == 1) begin
                r = ula_f(m_op, m_a, m_b);
                {m_cout, m_o} = r;
                m_zero = (m_o == '0);
                m_age = 2;
            end else if (m_age == 2 && rsp_ready) begin
                m_age = 0;
                m_prio = !m_owner;
                if (m_cnt[m_owner] < 255) m_cnt[m_owner]++;
            end
        end
    end

    // inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick(); tick();
        rst = 0;
        #3;
        ck("reset rsp_o", rsp_o, 0);
        ck("reset alu_r", alu_r, 0);
        ck("reset rsp0_valid", rsp0_valid, 0);
        ck("reset alu_s", alu_s, 0);

        // single add: 20 + 15 = 35 -> o=3, cout=1
        tick();
        req0_valid = 1; req0_op = 4'd0; req0_a = 5'd20; req0_b = 5'd15;
        #3; ck("add ready0", req0_ready, 1); ck("add ready1", req1_ready, 0);
        tick();
        req0_valid = 0; req0_a = 5'd31;
        #3; ck("add alu_r", alu_r, 1); ck("add alu_a", alu_a, 20); ck("add alu_b", alu_b, 15);
        tick();
        #3; ck("add rsp0_valid", rsp0_valid, 1); ck("add rsp_o", rsp_o, 3);
        ck("add cout", rsp_cout, 1); ck("add zero", rsp_zero, 0); ck("add rsp1_valid", rsp1_valid, 0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;

        // zero flag: 7 - 7
        req1_valid = 1; req1_op = 4'd1; req1_a = 5'd7; req1_b = 5'd7;
        #3; ck("zero ready1", req1_ready, 1);
        tick();
        req1_valid = 0;
        tick();
        #3; ck("zero rsp1_valid", rsp1_valid, 1); ck("zero rsp_o", rsp_o, 0);
        ck("zero flag", rsp_zero, 1); ck("zero cout", rsp_cout, 0); ck("zero rsp0_valid", rsp0_valid, 0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;

        // contention after reset
        rst = 1; tick(); rst = 0;
        req0_valid = 1; req0_op = 4'd0;  req0_a = 5'd1; req0_b = 5'd1;
        req1_valid = 1; req1_op = 4'd15; req1_a = 5'd0; req1_b = 5'd9;
        #3; ck("cont ready0", req0_ready, 1); ck("cont ready1", req1_ready, 0);
        tick(); tick();
        #3; ck("cont rsp0_valid", rsp0_valid, 1); ck("cont rsp_o 2", rsp_o, 2);
        rsp_ready = 1;
        tick();
        #3; ck("cont ready1 next", req1_ready, 1); ck("cont ready0 next", req0_ready, 0);
        tick(); tick();
        #3; ck("cont rsp1_valid", rsp1_valid, 1); ck("cont rsp_o 9", rsp_o, 9);
        for (int k = 0; k < 4; k++) begin
            tick();
            #3; ck("alt ready0", req0_ready, (k % 2) == 0); ck("alt ready1", req1_ready, (k % 2) == 1);
            tick(); tick();
        end
        req0_valid = 0; req1_valid = 0;
        tick();
        rsp_ready = 0;

        // backpressure: 12 & 10 = 8 held while rsp_ready low
        req0_valid = 1; req0_op = 4'd2; req0_a = 5'd12; req0_b = 5'd10;
        #3; ck("bp ready0", req0_ready, 1);
        tick();
        req0_valid = 0; req1_valid = 1; req1_op = 4'd3; req1_a = 5'd1; req1_b = 5'd2;
        tick();
        for (int k = 0; k < 4; k++) begin
            #3; ck("bp rsp0_valid", rsp0_valid, 1); ck("bp rsp_o", rsp_o, 8);
            ck("bp ready1", req1_ready, 0); ck("bp alu_r", alu_r, 0);
            tick();
        end
        rsp_ready = 1;
        #3; ck("bp rsp0_valid last", rsp0_valid, 1);
        tick();
        rsp_ready = 0;
        #3; ck("bp released", rsp0_valid, 0); ck("bp ready1 after", req1_ready, 1);

        // reset during EXEC drops the op
        tick();
        req1_valid = 0; rst = 1;
        #3; ck("rm alu_r exec", alu_r, 1);
        tick();
        rst = 0;
        #3; ck("rm rsp0_valid", rsp0_valid, 0); ck("rm rsp1_valid", rsp1_valid, 0);
        ck("rm ready1", req1_ready, 0); ck("rm alu_r", alu_r, 0);
        ck("rm rsp_o", rsp_o, 0); ck("rm alu_a", alu_a, 0);
        tick(); tick();
        #3; ck("rm no rsp", rsp1_valid, 0);

        // random traffic
        repeat (3000) begin
            tick();
            rst        = ($urandom_range(0, 149) == 0);
            req0_valid = $urandom_range(0, 1);
            req1_valid = $urandom_range(0, 1);
            rsp_ready  = ($urandom_range(0, 9) < 6);
            req0_op = SW'($urandom); req0_a = W'($urandom); req0_b = W'($urandom);
            req1_op = SW'($urandom); req1_a = W'($urandom); req1_b = W'($urandom);
        end
        tick();
        rst = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;

`ifdef ULA_ARB_STATS_EN
        rst = 1; tick(); rst = 0;
        req0_valid = 1; req0_op = 4'd0; req0_a = 5'd3; req0_b = 5'd4;
        repeat (905) tick();
        req0_valid = 0;
        tick(); tick(); tick();
        #3; ck("stats ops0 sat", ops0_cnt, 255); ck("stats ops1", ops1_cnt, 0);
        rst = 1; tick(); rst = 0;
        #3; ck("stats ops0 rst", ops0_cnt, 0); ck("stats ops1 rst", ops1_cnt, 0);
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ula_arbiter.md
Name: ula_arbiter

Overview:
- Shares one 5-bit ULA datapath between two requesters.
- Each requester issues an operation: 4-bit opcode S plus 5-bit operands A and B.
- The block grants the ULA round-robin, drives S/A/B/R for exactly one execute cycle, and registers O/Cout/Zero into a response held until the owner accepts it.
- Sits between the two ULA clients and the ULA instance; the ULA stays purely combinational.

Parameters:
- W, 5, operand/result width; must match the ULA instance.
- SW, 4, opcode width; must match the ULA instance.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  SW  requester 0 opcode.
- req0_a  in  W  requester 0 operand A.
- req0_b  in  W  requester 0 operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same widths and meaning, requester 1.
- rsp0_valid  out  1  response for requester 0 available.
- rsp1_valid  out  1  response for requester 1 available.
- rsp_ready  in  1  owner of the current response accepts it.
- rsp_o  out  W  registered ULA result.
- rsp_cout  out  1  registered ULA carry.
- rsp_zero  out  1  registered ULA zero flag.
- alu_s  out  SW  to ULA S.
- alu_a  out  W  to ULA A.
- alu_b  out  W  to ULA B.
- alu_r  out  1  to ULA R.
- alu_o  in  W  from ULA O.
- alu_cout  in  1  from ULA Cout.
- alu_zero  in  1  from ULA Zero.

Behaviour:
- Reset values:
  - state = IDLE, prio = 0.
  - req*_ready = 0, rsp*_valid = 0.
  - rsp_o = 0, rsp_cout = 0, rsp_zero = 0.
  - alu_r = 0, alu_s = 0, alu_a = 0, alu_b = 0.
  - owner = 0; latched op/a/b = 0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - Grant rule: one valid wins; if both are valid, the requester indexed by prio wins.
  - reqN_ready = (state==IDLE) & reqN_valid & grantN. This is combinational from the valids.
  - Requesters must not make valid depend on ready.
  - At most one ready is high per cycle.
  - On handshake: latch op/a/b and owner, then go to EXEC.
  - With no valid, stay in IDLE.
- EXEC (exactly one cycle):
  - alu_r = 1; alu_s/a/b driven from the latched op/a/b.
  - At the end of the cycle, capture alu_o/alu_cout/alu_zero into the rsp_* registers and go to RESP.
- RESP:
  - rsp<owner>_valid = 1; the other rsp valid stays 0.
  - rsp_o/cout/zero are held stable.
  - On rsp_ready=1: go to IDLE and set prio = ~owner.
  - With rsp_ready=0: hold indefinitely.
  - rsp_ready is ignored outside RESP.
- Outside EXEC: alu_r = 0, and alu_s/a/b hold their last latched values.
- Latency:
  - Handshake at cycle N, EXEC at N+1, rsp valid from N+2.
  - Earliest next accept is the cycle after the rsp_ready handshake.
  - Peak throughput is 1 op per 3 cycles.
- Requester inputs are ignored after acceptance; changing them in EXEC/RESP does not affect the result.
- Width rules: result and flags are passed through unchanged from the ULA; the arbiter does no arithmetic.
- Reset mid-operation: rst in any state returns to IDLE next edge with all outputs at reset values. The in-flight op is dropped with no response.
- Fairness: with both requesters continuously valid and rsp_ready=1, grants alternate 0,1,0,1...

Optional Feature:
- Macro: ULA_ARB_STATS_EN.
- When defined, adds two ports:
  - ops0_cnt  out  8  completed operations for requester 0.
  - ops1_cnt  out  8  completed operations for requester 1.
- Counter behaviour:
  - Increment on the RESP-state rsp_ready handshake for the owner.
  - Saturate at 255.
  - Reset to 0 on rst.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single add: req0 op=0000, a=20, b=15 -> req0_ready in same cycle; alu_r=1 next cycle; rsp0_valid two cycles after accept with rsp_o=3, rsp_cout=1, rsp_zero=0; rsp1_valid=0.
- Zero flag: req1 op=0001, a=7, b=7 -> rsp1_valid with rsp_o=0, rsp_zero=1, rsp_cout=0.
- Contention: after reset, req0 and req1 both valid with op=0000 a=1 b=1 and op=1111 b=9 -> req0 granted first (rsp_o=2); req1 accepted on the cycle after the req0 response handshake (rsp_o=9); with both held valid, grants alternate 0,1,0,1.
- Backpressure: rsp_ready=0 for 4 cycles in RESP -> rsp0_valid and rsp_o held stable, no new ready, alu_r=0; accept completes only when rsp_ready=1.
- Reset mid-op: rst asserted during EXEC -> next cycle state IDLE, all valids/readies 0, alu_r=0, rsp_o=0; no response for the dropped op.
- Stats (ULA_ARB_STATS_EN): 300 back-to-back req0 ops -> ops0_cnt saturates at 255 and ops1_cnt stays 0; rst clears both.
